ram_seq_ctrl: RTL and testbench
===============================

Name: ram_seq_ctrl

Overview:
Parametrised simple dual-port RAM (inferred, one write port, one registered read port) with a built-in fill/verify sequencer.
- Idle: user write and read ports drive the RAM directly.
- On start: the sequencer owns both ports. It writes a seeded incrementing pattern to every location, reads it back, compares, and reports pass, error count and first failing address.
- Replaces the fixed 1-bit, address-counting RAM test harness used in FPGA board bring-up.

Parameters:
DATA_W, 16, RAM word width in bits.
ADDR_W, 9, address width in bits.
DEPTH, 512, number of words; DEPTH <= 2**ADDR_W, DEPTH >= 2.

Ports:
clk  in  1  system clock, 50 MHz on board
rst_n  in  1  asynchronous reset, active low
start  in  1  request a fill/verify run; sampled only in IDLE
seed  in  DATA_W  pattern base, captured on start acceptance
inject_en  in  1  fault injection enable, captured on start acceptance
inject_addr  in  ADDR_W  location whose written word gets bit 0 inverted, captured on start acceptance
busy  out  1  sequencer owns the RAM
done  out  1  one-cycle pulse: run finished
pass  out  1  last run had zero mismatches
err_cnt  out  ADDR_W+1  mismatch count of last run
first_err_addr  out  ADDR_W  lowest failing address of last run; 0 if none
wr_en  in  1  user write strobe
wr_addr  in  ADDR_W  user write address
wr_data  in  DATA_W  user write data
rd_en  in  1  user read strobe
rd_addr  in  ADDR_W  user read address
rd_valid  out  1  rd_data valid
rd_data  out  DATA_W  user read data

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active low.
- Reset values: busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, rd_valid=0, rd_data=0, state=IDLE. RAM contents are not reset.
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE
  - start=1 at edge N: capture seed, inject_en, inject_addr; clear pass, err_cnt, first_err_addr.
  - Enter WRITE at N+1 with address counter = 0.
- WRITE
  - One word per cycle at addresses 0..DEPTH-1.
  - Data = (seed + addr) mod 2**DATA_W, addr zero-extended.
  - If inject_en and addr == inject_addr, bit 0 of the data is inverted.
  - After address DEPTH-1 is written, go to READ with counter = 0.
- READ
  - Issue one read per cycle at addresses 0..DEPTH-1.
  - Each read returns one cycle later and is compared with the uninjected expected value.
  - After address DEPTH-1 is issued, go to DRAIN.
- DRAIN: one cycle; compares the last returned word.
- DONE: done=1 for exactly one cycle; then IDLE.
- busy is 1 in WRITE, READ and DRAIN, for exactly 2*DEPTH+1 cycles. busy=0 in DONE.
- Compare results
  - Each mismatch increments err_cnt; err_cnt saturates at DEPTH.
  - first_err_addr latches on the first mismatch only.
  - pass = (err_cnt == 0); it is updated on entry to DONE, not earlier.
  - pass, err_cnt and first_err_addr hold until the next start acceptance.
- start handling: ignored outside IDLE, including the DONE cycle. start held high re-launches on the first IDLE cycle.
- User ports, IDLE only
  - Write: wr_en=1 writes wr_data at wr_addr on that edge.
  - Read: rd_en=1 yields rd_valid=1 with rd_data at the next edge. Latency is 1.
  - Same-address read and write in the same cycle return the old data (read-first).
  - Addresses >= DEPTH: writes are dropped; reads return rd_data=0 with rd_valid=1.
- User ports, outside IDLE: wr_en and rd_en are ignored. rd_valid stays 0, except a read issued in the start-acceptance cycle, which completes normally.
- Reset mid-run: sequencer returns to IDLE with all outputs at reset values. Partially written RAM contents are retained.

Test Plan:
1. Reset, then write 0xA5A5 at address 3 and read address 3 the next cycle -> rd_valid=1 with rd_data=0xA5A5 exactly one cycle after rd_en. Read address 600 (>= DEPTH) -> rd_data=0, rd_valid=1.
2. start with seed=0x0100, inject_en=0 -> busy high for 1025 cycles; done pulses one cycle; pass=1, err_cnt=0. A user read of address 7 afterwards -> 0x0107.
3. start with seed=0xFFFE, inject_en=1, inject_addr=5 -> pass=0, err_cnt=1, first_err_addr=5. User read of address 5 -> 0x0002 (0x0003 with bit 0 inverted). Address 1 -> 0xFFFF; address 2 -> 0x0000 (wrap).
4. Pulse start and hold wr_en=1 at address 10 during the run; pulse start again mid-READ -> the write is ignored, the second start is ignored, and exactly one done pulse occurs. Address 10 reads back as seed+10 afterwards.
5. Assert rst_n=0 for 2 cycles mid-WRITE (counter=100) -> busy=0, done=0, err_cnt=0 immediately. A new start then runs a full 2*DEPTH+1-cycle run with pass=1.
6. Sweep DEPTH=4, ADDR_W=2 and DEPTH=5, ADDR_W=3, DATA_W=8 -> busy lasts 9 and 11 cycles respectively. For DEPTH=5, inject_addr=4 is detected and inject_addr=6 causes no error.

Source files
------------

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl
// Simple dual-port RAM (one write port, one registered read port) with a
// built-in fill/verify sequencer for board bring-up.
//
// While idle the user ports drive the RAM directly. A start request hands
// both ports to the sequencer. It writes (seed + addr) to every word, with an
// optional single-bit fault injected at one address. It then reads every word
// back, compares against the clean pattern, and reports pass / error count /
// lowest failing address.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run request, sampled only in IDLE
//   seed                  pattern base (captured on start acceptance)
//   inject_en/inject_addr fault injection control (captured on acceptance)
//   busy                  sequencer owns the RAM (WRITE, READ, DRAIN)
//   done                  one-cycle pulse at end of run
//   pass                  last run had no mismatches
//   err_cnt               mismatch count of last run, saturating at DEPTH
//   first_err_addr        lowest failing address of last run, 0 if none
//   wr_en/wr_addr/wr_data user write port (IDLE only)
//   rd_en/rd_addr         user read request (IDLE only), latency 1
//   rd_valid/rd_data      user read response; out-of-range reads return 0
module ram_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    input  logic              inject_en,
    input  logic [ADDR_W-1:0] inject_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ERR_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   ERR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Test pattern: seed plus zero-extended address, wrapping at DATA_W bits.
    function automatic logic [DATA_W-1:0] pattern_word(
        input logic [DATA_W-1:0] base,
        input logic [ADDR_W-1:0] addr
    );
        return base + DATA_W'(addr);
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]   cnt_nxt_s;
    logic                accept_s;

    logic [DATA_W-1:0]   seed_r;
    logic                inj_en_r;
    logic [ADDR_W-1:0]   inj_addr_r;

    logic                busy_r;
    logic                done_r;
    logic                pass_r;
    logic [ADDR_W:0]     err_cnt_r;
    logic [ADDR_W-1:0]   first_err_addr_r;
    logic [ADDR_W:0]     err_cnt_nxt_s;
    logic [ADDR_W-1:0]   first_err_nxt_s;

    logic                cmp_valid_r;
    logic [ADDR_W-1:0]   cmp_addr_r;
    logic [DATA_W-1:0]   expect_s;
    logic                mismatch_s;

    logic                rd_valid_r;
    logic                rd_oor_r;

    logic                ram_we_s;
    logic [ADDR_W-1:0]   ram_waddr_s;
    logic [DATA_W-1:0]   ram_wdata_s;
    logic                ram_re_s;
    logic [ADDR_W-1:0]   ram_raddr_s;
    logic [DATA_W-1:0]   ram_q_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Next-state and address counter for the fill/verify sequence.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WRITE;
                    cnt_nxt_s   = ADDR_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_READ;
                    cnt_nxt_s   = ADDR_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + ADDR_ONE;
                end
            end
            ST_READ: begin
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = ADDR_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + ADDR_ONE;
                end
            end
            ST_DRAIN: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // RAM port ownership: user ports in IDLE, sequencer in WRITE/READ, nobody otherwise.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = ADDR_ZERO;
        ram_wdata_s = DATA_ZERO;
        ram_re_s    = 1'b0;
        ram_raddr_s = ADDR_ZERO;
        case (state_r)
            ST_IDLE: begin
                // Out-of-range writes are dropped rather than aliased.
                ram_we_s    = wr_en && ({1'b0, wr_addr} < DEPTH_C);
                ram_waddr_s = wr_addr;
                ram_wdata_s = wr_data;
                ram_re_s    = rd_en;
                ram_raddr_s = rd_addr;
            end
            ST_WRITE: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = cnt_r;
                ram_wdata_s = pattern_word(seed_r, cnt_r)
                            ^ DATA_W'(inj_en_r && (cnt_r == inj_addr_r));
            end
            ST_READ: begin
                ram_re_s    = 1'b1;
                ram_raddr_s = cnt_r;
            end
            default: begin
                ram_we_s = 1'b0;
                ram_re_s = 1'b0;
            end
        endcase
    end

    // Compare the word returned from last cycle's sequencer read.
    always_comb begin
        expect_s        = pattern_word(seed_r, cmp_addr_r);
        mismatch_s      = cmp_valid_r && (ram_q_r != expect_s);
        err_cnt_nxt_s   = err_cnt_r;
        first_err_nxt_s = first_err_addr_r;
        if (mismatch_s) begin
            if (err_cnt_r < DEPTH_C) begin
                err_cnt_nxt_s = err_cnt_r + ERR_ONE;
            end else begin
                err_cnt_nxt_s = err_cnt_r;
            end
            if (err_cnt_r == ERR_ZERO) begin
                first_err_nxt_s = cmp_addr_r;
            end else begin
                first_err_nxt_s = first_err_addr_r;
            end
        end else begin
            err_cnt_nxt_s   = err_cnt_r;
            first_err_nxt_s = first_err_addr_r;
        end
    end

    // Sequencer state, run parameters and status strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= ADDR_ZERO;
            seed_r      <= DATA_ZERO;
            inj_en_r    <= 1'b0;
            inj_addr_r  <= ADDR_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cmp_valid_r <= 1'b0;
            cmp_addr_r  <= ADDR_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            busy_r      <= (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_READ)
                        || (state_nxt_s == ST_DRAIN);
            done_r      <= (state_nxt_s == ST_DONE);
            cmp_valid_r <= (state_r == ST_READ);
            cmp_addr_r  <= cnt_r;
            if (accept_s) begin
                seed_r     <= seed;
                inj_en_r   <= inject_en;
                inj_addr_r <= inject_addr;
            end
        end
    end

    // Run results: cleared on acceptance, pass resolved on the DRAIN->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_r           <= 1'b0;
            err_cnt_r        <= ERR_ZERO;
            first_err_addr_r <= ADDR_ZERO;
        end else if (accept_s) begin
            pass_r           <= 1'b0;
            err_cnt_r        <= ERR_ZERO;
            first_err_addr_r <= ADDR_ZERO;
        end else begin
            err_cnt_r        <= err_cnt_nxt_s;
            first_err_addr_r <= first_err_nxt_s;
            if (state_r == ST_DRAIN) begin
                pass_r <= (err_cnt_nxt_s == ERR_ZERO);
            end
        end
    end

    // User read response tracking; a read in the acceptance cycle still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_oor_r   <= 1'b0;
        end else begin
            rd_valid_r <= (state_r == ST_IDLE) && rd_en;
            rd_oor_r   <= ({1'b0, rd_addr} >= DEPTH_C);
        end
    end

    // RAM write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // RAM registered read port; read-first on a same-address collision.
    always_ff @(posedge clk) begin
        if (ram_re_s) begin
            ram_q_r <= mem_r[ram_raddr_s];
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_cnt        = err_cnt_r;
    assign first_err_addr = first_err_addr_r;
    assign rd_valid       = rd_valid_r;
    // Gated so out-of-range reads and idle cycles present zero.
    assign rd_data        = (rd_valid_r && !rd_oor_r) ? ram_q_r : DATA_ZERO;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed testbench for ram_seq_ctrl: user port access, clean and faulted
// fill/verify runs, start/write blocking during a run, mid-run reset, and
// small-depth instances.
module tb_ram_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start_v;
    wire  [2:0]  busy_v;
    wire  [2:0]  done_v;
    wire  [2:0]  pass_v;

    // Main instance: DEPTH 512 in a 10-bit address space so out-of-range
    // addresses such as 600 exist.
    logic [15:0] seed;
    logic        inject_en;
    logic [9:0]  inject_addr;
    wire  [10:0] err_cnt;
    wire  [9:0]  first_err_addr;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [9:0]  rd_addr;
    wire         rd_valid;
    wire  [15:0] rd_data;

    logic [15:0] seed4;
    wire  [2:0]  err4;
    wire  [1:0]  first4;
    wire         rdv4;
    wire  [15:0] rdd4;

    logic [7:0]  seed5;
    logic        inj5_en;
    logic [2:0]  inj5_addr;
    wire  [3:0]  err5;
    wire  [2:0]  first5;
    wire         rdv5;
    wire  [7:0]  rdd5;

    int n_vec  = 0;
    int n_miss = 0;
    int bcnt;
    int dcnt;
    logic pass_early;

    ram_seq_ctrl #(.DATA_W(16), .ADDR_W(10), .DEPTH(512)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .seed(seed),
        .inject_en(inject_en), .inject_addr(inject_addr),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    ram_seq_ctrl #(.DATA_W(16), .ADDR_W(2), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .seed(seed4),
        .inject_en(1'b0), .inject_addr(2'd0),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_cnt(err4), .first_err_addr(first4),
        .wr_en(1'b0), .wr_addr(2'd0), .wr_data(16'h0000),
        .rd_en(1'b0), .rd_addr(2'd0), .rd_valid(rdv4), .rd_data(rdd4)
    );

    ram_seq_ctrl #(.DATA_W(8), .ADDR_W(3), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .seed(seed5),
        .inject_en(inj5_en), .inject_addr(inj5_addr),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_cnt(err5), .first_err_addr(first5),
        .wr_en(1'b0), .wr_addr(3'd0), .wr_data(8'h00),
        .rd_en(1'b0), .rd_addr(3'd0), .rd_valid(rdv5), .rd_data(rdd5)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch a run on instance sel; count busy cycles and done pulses, optionally
    // pulsing start again at busy cycle mid_at. Bounded by a cycle budget.
    task automatic run_seq(input int sel, input int mid_at,
                           output int b, output int d, output logic pe);
        int tail;
        b    = 0;
        d    = 0;
        pe   = 1'b1;
        tail = -1;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        for (int i = 0; i < 4000 && tail != 0; i++) begin
            if (busy_v[sel]) begin
                b++;
                if (b == 1) pe = pass_v[sel];
            end
            if (done_v[sel]) begin
                d++;
                wr_en = 1'b0;
                if (tail < 0) tail = 3;
            end
            start_v[sel] = (mid_at != 0) && (b == mid_at);
            @(negedge clk);
            if (tail > 0) tail--;
        end
        start_v[sel] = 1'b0;
        if (tail != 0) check_val("run_timeout", 32'd1, 32'd0);
    endtask

    task automatic user_read(input logic [9:0] a, input string tag, input logic [15:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en   = 1'b0;
        check_val({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check_val(tag, {16'd0, rd_data}, {16'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        start_v = 3'b000;
        seed = 16'h0000; inject_en = 1'b0; inject_addr = 10'd0;
        wr_en = 1'b0; wr_addr = 10'd0; wr_data = 16'h0000;
        rd_en = 1'b0; rd_addr = 10'd0;
        seed4 = 16'h0000; seed5 = 8'h00; inj5_en = 1'b0; inj5_addr = 3'd0;

        // Reset values
        @(negedge clk);
        check_val("rst_busy",  {29'd0, busy_v}, 32'd0);
        check_val("rst_done",  {29'd0, done_v}, 32'd0);
        check_val("rst_pass",  {29'd0, pass_v}, 32'd0);
        check_val("rst_err",   {21'd0, err_cnt}, 32'd0);
        check_val("rst_first", {22'd0, first_err_addr}, 32'd0);
        check_val("rst_rdv",   {29'd0, rd_valid, rdv4, rdv5}, 32'd0);
        check_val("rst_rdd",   {16'd0, rd_data}, 32'd0);
        check_val("rst_small", {11'd0, err4, first4, err5, first5, rdd5}, 32'd0);
        check_val("rst_rdd4",  {16'd0, rdd4}, 32'd0);
        rst_n = 1'b1;

        // User ports: write, latency-1 read, read-first collision, out of range
        wr_en = 1'b1; wr_addr = 10'd3; wr_data = 16'hA5A5;
        @(negedge clk);
        wr_en = 1'b0;
        check_val("t1_noread_valid", {31'd0, rd_valid}, 32'd0);
        user_read(10'd3, "t1_rd3", 16'hA5A5);
        wr_en = 1'b1; wr_addr = 10'd3; wr_data = 16'h1111;
        user_read(10'd3, "t1_rdfirst", 16'hA5A5);
        wr_en = 1'b0;
        user_read(10'd3, "t1_rd3_new", 16'h1111);
        wr_en = 1'b1; wr_addr = 10'd600; wr_data = 16'hBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        user_read(10'd600, "t1_rd600", 16'h0000);
        @(negedge clk);
        check_val("t1_valid_drop", {31'd0, rd_valid}, 32'd0);

        // Clean run
        seed = 16'h0100; inject_en = 1'b0;
        run_seq(0, 0, bcnt, dcnt, pass_early);
        check_val("t2_busy_cycles", bcnt, 32'd1025);
        check_val("t2_done_pulses", dcnt, 32'd1);
        check_val("t2_pass", {31'd0, pass_v[0]}, 32'd1);
        check_val("t2_err", {21'd0, err_cnt}, 32'd0);
        check_val("t2_first", {22'd0, first_err_addr}, 32'd0);
        user_read(10'd7, "t2_rd7", 16'h0107);

        // Faulted run with wrap-around pattern
        seed = 16'hFFFE; inject_en = 1'b1; inject_addr = 10'd5;
        run_seq(0, 0, bcnt, dcnt, pass_early);
        inject_en = 1'b0;
        check_val("t3_pass_cleared", {31'd0, pass_early}, 32'd0);
        check_val("t3_busy_cycles", bcnt, 32'd1025);
        check_val("t3_pass", {31'd0, pass_v[0]}, 32'd0);
        check_val("t3_err", {21'd0, err_cnt}, 32'd1);
        check_val("t3_first", {22'd0, first_err_addr}, 32'd5);
        user_read(10'd5, "t3_rd5", 16'h0002);
        user_read(10'd1, "t3_rd1", 16'hFFFF);
        user_read(10'd2, "t3_rd2", 16'h0000);
        user_read(10'd6, "t3_rd6", 16'h0004);

        // Writes and a second start during a run are ignored
        seed = 16'h1234;
        wr_en = 1'b1; wr_addr = 10'd10; wr_data = 16'hDEAD;
        run_seq(0, 612, bcnt, dcnt, pass_early);
        wr_en = 1'b0;
        check_val("t4_busy_cycles", bcnt, 32'd1025);
        check_val("t4_done_pulses", dcnt, 32'd1);
        check_val("t4_pass", {31'd0, pass_v[0]}, 32'd1);
        user_read(10'd10, "t4_rd10", 16'h123E);

        // Reset in the middle of WRITE
        seed = 16'h0042;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (100) @(negedge clk);
        check_val("t5_busy_pre", {31'd0, busy_v[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("t5_busy_rst", {31'd0, busy_v[0]}, 32'd0);
        check_val("t5_done_rst", {31'd0, done_v[0]}, 32'd0);
        check_val("t5_err_rst", {21'd0, err_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_seq(0, 0, bcnt, dcnt, pass_early);
        check_val("t5_busy_cycles", bcnt, 32'd1025);
        check_val("t5_pass", {31'd0, pass_v[0]}, 32'd1);
        user_read(10'd100, "t5_rd100", 16'h00A6);

        // Small depths
        seed4 = 16'h0010;
        run_seq(1, 0, bcnt, dcnt, pass_early);
        check_val("t6_d4_busy", bcnt, 32'd9);
        check_val("t6_d4_done", dcnt, 32'd1);
        check_val("t6_d4_pass", {31'd0, pass_v[1]}, 32'd1);
        check_val("t6_d4_err", {29'd0, err4}, 32'd0);

        seed5 = 8'hFC; inj5_en = 1'b1; inj5_addr = 3'd4;
        run_seq(2, 0, bcnt, dcnt, pass_early);
        check_val("t6_d5_busy", bcnt, 32'd11);
        check_val("t6_d5_pass_inj4", {31'd0, pass_v[2]}, 32'd0);
        check_val("t6_d5_err_inj4", {28'd0, err5}, 32'd1);
        check_val("t6_d5_first_inj4", {29'd0, first5}, 32'd4);

        inj5_addr = 3'd6;
        run_seq(2, 0, bcnt, dcnt, pass_early);
        check_val("t6_d5_busy_inj6", bcnt, 32'd11);
        check_val("t6_d5_pass_inj6", {31'd0, pass_v[2]}, 32'd1);
        check_val("t6_d5_err_inj6", {28'd0, err5}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
